// File: rtl/bus_port_arbiter_if.sv
// bus_port_arbiter_if: groups the device push side and the arbitrated bus
// output of bus_port_arbiter into one bundle.
//   push/D_push   : per-port push strobe and packed packet data
//   full/pndng    : per-port FIFO status (registered)
//   ovf/clr_ovf   : sticky per-port drop flags and their common clear
//   bus_valid/bus_ready/bus_data/bus_src : registered output with handshake
// Modport master is the arbiter; modport slave is its environment.
interface bus_port_arbiter_if #(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16
);
  localparam int src_w = (drvrs > 1) ? $clog2(drvrs) : 1;

  logic [drvrs-1:0]         push;
  logic [drvrs*pckg_sz-1:0] D_push;
  logic [drvrs-1:0]         full;
  logic [drvrs-1:0]         pndng;
  logic [drvrs-1:0]         ovf;
  logic                     clr_ovf;
  logic                     bus_valid;
  logic                     bus_ready;
  logic [pckg_sz-1:0]       bus_data;
  logic [src_w-1:0]         bus_src;

  modport master (
    input  push, D_push, clr_ovf, bus_ready,
    output full, pndng, ovf, bus_valid, bus_data, bus_src
  );

  modport slave (
    output push, D_push, clr_ovf, bus_ready,
    input  full, pndng, ovf, bus_valid, bus_data, bus_src
  );
endinterface

// File: rtl/bus_port_arbiter.sv
// bus_port_arbiter: per-device packet FIFOs drained by a round-robin arbiter
// onto a single registered bus output with a valid/ready handshake.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bus_port_arbiter_if.master (push side, status flags, bus output)
module bus_port_arbiter #(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16,
  parameter int depth   = 8
) (
  input logic                clk,
  input logic                rst_n,
  bus_port_arbiter_if.master bus
);
  localparam int src_w = (drvrs > 1) ? $clog2(drvrs) : 1;
  localparam int aw    = $clog2(depth);
  localparam int cw    = aw + 1;

  logic [pckg_sz-1:0] mem [drvrs][depth];
  logic [aw-1:0]      rd_ptr [drvrs];
  logic [aw-1:0]      wr_ptr [drvrs];
  logic [cw-1:0]      cnt    [drvrs];
  logic [cw-1:0]      cnt_nxt[drvrs];

  logic [drvrs-1:0]   full_r, pndng_r, ovf_r;
  logic [drvrs-1:0]   pop, acc, drop;

  logic               vld_p0;
  logic [pckg_sz-1:0] data_p0;
  logic [src_w-1:0]   src_p0;
  logic [src_w-1:0]   last_grant;

  logic               slot_free;
  logic               gnt_any;
  logic [src_w-1:0]   gnt_idx;

  assign slot_free = !vld_p0 || bus.bus_ready;

  // Round-robin search starting just after the last granted port.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    pop     = '0;
    if (slot_free) begin
      for (int k = 1; k <= drvrs; k++) begin
        idx = (int'(last_grant) + k) % drvrs;
        if (!gnt_any && pndng_r[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = src_w'(idx);
        end
      end
    end
    if (gnt_any) pop[gnt_idx] = 1'b1;
  end

  // A push into a full FIFO survives only when the same port pops this cycle.
  always_comb begin
    for (int i = 0; i < drvrs; i++) begin
      acc[i]     = bus.push[i] && (!full_r[i] || pop[i]);
      drop[i]    = bus.push[i] && !acc[i];
      cnt_nxt[i] = cnt[i] + cw'(acc[i]) - cw'(pop[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < drvrs; i++) begin
        cnt[i]    <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
      full_r  <= '0;
      pndng_r <= '0;
      ovf_r   <= '0;
    end else begin
      for (int i = 0; i < drvrs; i++) begin
        cnt[i]     <= cnt_nxt[i];
        full_r[i]  <= (cnt_nxt[i] == cw'(depth));
        pndng_r[i] <= (cnt_nxt[i] != '0);
        if (acc[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
      // Clear wins over a same-cycle drop.
      if (bus.clr_ovf) ovf_r <= '0;
      else             ovf_r <= ovf_r | drop;
    end
  end

  // Packet storage carries no reset; validity lives in the counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < drvrs; i++) begin
      if (acc[i]) mem[i][wr_ptr[i]] <= bus.D_push[i*pckg_sz +: pckg_sz];
    end
  end

  // Output stage p0: single bus register, loaded only when the slot is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      data_p0    <= '0;
      src_p0     <= '0;
      last_grant <= src_w'(drvrs - 1);
    end else if (slot_free) begin
      if (gnt_any) begin
        vld_p0     <= 1'b1;
        data_p0    <= mem[gnt_idx][rd_ptr[gnt_idx]];
        src_p0     <= gnt_idx;
        last_grant <= gnt_idx;
      end else begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign bus.full      = full_r;
  assign bus.pndng     = pndng_r;
  assign bus.ovf       = ovf_r;
  assign bus.bus_valid = vld_p0;
  assign bus.bus_data  = data_p0;
  assign bus.bus_src   = src_p0;
endmodule

// File: doc/bus_port_arbiter.md
# bus_port_arbiter

Per-device input queueing and bus-access arbitration stage for the multi-driver bus. Each of `drvrs` devices pushes `pckg_sz`-bit packets into its own FIFO. In our environment these pushes come from the driver side of the Driver/Monitor agent. A round-robin arbiter drains the FIFOs one packet at a time onto a single registered bus output with a valid/ready handshake. The bus output is consumed downstream by the bus/monitor side.

## Interface
- `drvrs`, 4: number of device ports (≥2).
- `pckg_sz`, 16: packet width in bits.
- `depth`, 8: entries per port FIFO (power of 2, ≥2).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `push` in `drvrs`: per-port push strobe.
- `D_push` in `drvrs*pckg_sz`: port i data at `[i*pckg_sz +: pckg_sz]`.
- `full` out `drvrs`: port FIFO holds `depth` entries.
- `pndng` out `drvrs`: port FIFO non-empty.
- `ovf` out `drvrs`: sticky, set when a push is dropped.
- `clr_ovf` in 1: clears all `ovf` bits.
- `bus_valid` out 1: output register holds a packet.
- `bus_ready` in 1: consumer accepts the packet when high together with `bus_valid`.
- `bus_data` out `pckg_sz`: packet.
- `bus_src` out `max(1,$clog2(drvrs))`: originating port index.

## Operation
- Each port has a circular FIFO with read pointer, write pointer and an occupancy count of 0..`depth`. Pointers wrap modulo `depth`.
- Push handling:
  - A push to a non-full port writes the data and increments the count.
  - A push to a full port is accepted only if the same port is popped in the same cycle; the count is then unchanged.
  - Otherwise the push is dropped, `ovf[i]` is set and the FIFO is unchanged.
- `full` and `pndng` are registered, derived from the next count, so they are valid the cycle after the edge that changed the count.
- The output stage is a single register. The output slot is "free" when `!bus_valid || bus_ready`.
- When the slot is free and any `pndng` bit is set, the arbiter grants the first pending port searching from `last_grant+1` upward, with wrap-around.
- On a grant:
  - the arbiter pops that port's head into `bus_data`;
  - `bus_src` is loaded with the granted index;
  - `bus_valid` goes to 1;
  - `last_grant` is loaded with the granted index.
- When the slot is free and nothing is pending, `bus_valid` goes to 0. `bus_data` and `bus_src` hold their old values.
- While `bus_valid && !bus_ready`, `bus_data` and `bus_src` are stable and no pop occurs.
- There is no bypass: a packet never reaches the bus in the same cycle it is pushed.
- `clr_ovf` has priority over a same-cycle overflow set, so a set in that cycle is lost.

## Timing
- Reset values (asserted asynchronously):
  - all pointers and counts 0;
  - `full`, `pndng`, `ovf` = 0;
  - `bus_valid` = 0, `bus_data` = 0, `bus_src` = 0;
  - `last_grant` = `drvrs-1`, so the first grant goes to port 0.
- Assertion of `rst_n` mid-operation discards all queued and in-flight packets immediately. Outputs go to their reset values without waiting for a clock edge.
- Latency:
  - A push sampled at edge k sets `pndng` after edge k.
  - The earliest pop is at edge k+1, so `bus_valid` is high after edge k+1.
- Throughput: one packet per cycle while `bus_ready` = 1 and data is pending.
- Handshake: a transfer occurs on each edge where `bus_valid && bus_ready`.
- Simultaneous events:
  - A push and a pop on the same port leave the count unchanged.
  - A push and a pop on an empty FIFO cannot coincide, because no pop is possible from an empty FIFO.

## Test plan
- **Single packet:** push port 2 with 0x00A5, `bus_ready`=1. Required response:
  - `bus_valid` high 2 edges after the push with `bus_data`=0x00A5 and `bus_src`=2;
  - `pndng[2]` returns to 0;
  - `bus_valid` drops the next cycle.
- **Simultaneous pushes:** all ports push 0x1111, 0x2222, 0x3333, 0x4444 in one cycle, `bus_ready`=1. Required response: back-to-back outputs with `bus_src` 0, 1, 2, 3, each carrying its matching data.
- **Fairness:** ports 0 and 3 each push 3 packets, `bus_ready`=1. Required response: `bus_src` sequence is 0, 3, 0, 3, 0, 3.
- **Backpressure and overflow:** `bus_ready`=0, then port 1 pushes 0x0100..0x0109 on 10 consecutive cycles.
  - Required while stalled: `bus_data`=0x0100 held, `full[1]`=1 after the 9th push, 0x0109 dropped, `ovf[1]`=1.
  - Then raise `bus_ready`. Required: 0x0100..0x0108 appear in order and 0x0109 never appears.
  - Then pulse `clr_ovf`. Required: `ovf[1]`=0.
- **Full with push and pop:** port 0 full, output slot free, push 0xBEEF in the same cycle as the pop. Required response:
  - the push is accepted;
  - `full[0]` stays 1;
  - `ovf[0]`=0;
  - 0xBEEF emerges last.
- **Reset mid-operation:** 5 packets queued and `bus_valid`=1. Drop `rst_n` between clock edges for 3 cycles. Required response:
  - `bus_valid`, `pndng`, `full` and `ovf` go to 0 immediately;
  - after release, no stale packet appears;
  - a new push to port 3 is granted first, via wrap-around from `last_grant`=`drvrs-1`.
